dbus_arbiter: RTL and testbench
===============================

DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 Parameter: p_STARVE_LIMIT, default 8, range 1..15; number of consecutive blocked M1 request cycles before M1 is forced to win.
REQ-002 i_Clk  in  1  single clock; all state updates on its rising edge.
REQ-003 i_Rst_n  in  1  reset, asynchronous and active-low.
REQ-004 i_Mx_Address  in  30  master x (x = 0 CPU, x = 1 DMA) word address.
REQ-005 i_Mx_ByteEn  in  4  master x byte enables.
REQ-006 i_Mx_Read / i_Mx_Write  in  1 each  master x read / write request.
REQ-007 i_Mx_WriteData  in  32  master x write data.
REQ-008 o_Mx_Wait  out  1  master x must hold its request unchanged while this is high.
REQ-009 o_Mx_ReadData  out  32  read data returned to master x.
REQ-010 o_Mx_ReadValid  out  1  o_Mx_ReadData is valid this cycle.
REQ-011 o_DBus_Address  out  30; o_DBus_ByteEn  out  4; o_DBus_Read, o_DBus_Write  out  1; o_DBus_WriteData  out  32: shared slave bus.
REQ-012 i_DBus_ReadData  in  32  slave read data, valid exactly 1 cycle after an accepted read.
REQ-013 i_DBus_WaitRequest  in  1  slave stall; a command is accepted only in a cycle where it is presented and this is low.

Function
REQ-014 A master requests when its Read or Write is high; if both are high, the master issues a write and o_DBus_Read is forced to 0.
REQ-015 FSM states: IDLE, LOCK_M0, LOCK_M1.
REQ-016 IDLE arbitration (combinational, same cycle): if M1 requests and r_StarveCnt == p_STARVE_LIMIT, grant M1; else if M0 requests, grant M0; else if M1 requests, grant M1; else no grant.
REQ-017 IDLE: if the granted command is stalled (i_DBus_WaitRequest high), next state is LOCK_Mx for the granted master; otherwise remain in IDLE.
REQ-018 LOCK_Mx: grant is fixed to Mx regardless of other requests; return to IDLE in the first cycle with i_DBus_WaitRequest low.
REQ-019 A request dropped by the locked master while stalled is a protocol error; the FSM returns to IDLE on the next edge and no command is issued.
REQ-020 The o_DBus_* command outputs carry the granted master's inputs unregistered (zero added latency); with no grant, all command outputs are 0.
REQ-021 o_Mx_Wait = Mx requesting AND NOT (Mx granted AND i_DBus_WaitRequest low).
REQ-022 On each accepted read, r_RdTag <= {valid = 1, master id}; otherwise r_RdTag.valid <= 0.
REQ-023 o_Mx_ReadValid = r_RdTag.valid AND tag id == x; o_Mx_ReadData = i_DBus_ReadData when o_Mx_ReadValid is high, else 0.
REQ-024 Back-to-back accepted reads from alternating masters return data on consecutive cycles, each routed to its own master.
REQ-025 r_StarveCnt (4 bits): +1 each cycle M1 requests and is not accepted, saturating at p_STARVE_LIMIT; cleared when M1 is accepted or M1 is not requesting.
REQ-026 Accepted writes produce no read-return activity.

Reset
REQ-027 While i_Rst_n is low: FSM = IDLE, r_RdTag = 0, r_StarveCnt = 0, all o_Mx_ReadValid = 0, all o_Mx_ReadData = 0.
REQ-028 During reset, o_DBus_Read and o_DBus_Write are 0 and both o_Mx_Wait equal their master's request.
REQ-029 Reset asserted mid-stall (LOCK_Mx) or with a read in flight discards the lock and the tag; the returning read data is delivered to no master.
REQ-030 First arbitration occurs in the first cycle after i_Rst_n goes high.

Verification
REQ-031 M0 read at 0x0000100, no stall -> o_DBus_Read = 1 in the same cycle, o_M0_Wait = 0; the next cycle i_DBus_ReadData = 0xDEADBEEF gives o_M0_ReadValid = 1 and o_M0_ReadData = 0xDEADBEEF, with o_M1_ReadValid = 0.
REQ-032 M0 and M1 both write in the same cycle -> M0 is granted and o_M1_Wait = 1; M1 is accepted in the cycle after M0 completes.
REQ-033 M0 writes ByteEn 0011 with 3 stall cycles while M1 requests -> grant stays on M0 (LOCK_M0) for all stalled cycles and the M0 data is unchanged on o_DBus_*; M1 is granted after the stall clears.
REQ-034 M0 requests continuously, M1 requests, p_STARVE_LIMIT = 8 -> M1 is accepted after exactly 8 blocked cycles, and r_StarveCnt then reads 0.
REQ-035 M0 read accepted then M1 read accepted in the next cycle -> o_M0_ReadValid and o_M1_ReadValid are each high for 1 cycle, on consecutive cycles.
REQ-036 i_Rst_n pulsed low during LOCK_M1 with a read in flight -> all valids are 0, the FSM is IDLE, and o_DBus_Read/Write are 0 immediately.

Source files
------------

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: two-master (CPU, DMA) arbiter for a shared data bus with stall locking,
// M1 starvation protection and read-return routing.
module dbus_arbiter #(
   parameter int p_STARVE_LIMIT = 8
) (
   input  logic        i_Clk,
   input  logic        i_Rst_n,
   input  logic [29:0] i_M0_Address,
   input  logic [3:0]  i_M0_ByteEn,
   input  logic        i_M0_Read,
   input  logic        i_M0_Write,
   input  logic [31:0] i_M0_WriteData,
   output logic        o_M0_Wait,
   output logic [31:0] o_M0_ReadData,
   output logic        o_M0_ReadValid,
   input  logic [29:0] i_M1_Address,
   input  logic [3:0]  i_M1_ByteEn,
   input  logic        i_M1_Read,
   input  logic        i_M1_Write,
   input  logic [31:0] i_M1_WriteData,
   output logic        o_M1_Wait,
   output logic [31:0] o_M1_ReadData,
   output logic        o_M1_ReadValid,
   output logic [29:0] o_DBus_Address,
   output logic [3:0]  o_DBus_ByteEn,
   output logic        o_DBus_Read,
   output logic        o_DBus_Write,
   output logic [31:0] o_DBus_WriteData,
   input  logic [31:0] i_DBus_ReadData,
   input  logic        i_DBus_WaitRequest
);
   typedef enum logic [1:0] {IDLE, LOCK_M0, LOCK_M1} state_t;
   localparam logic [3:0] LIMIT = 4'(p_STARVE_LIMIT);
   state_t      state_q, state_d;
   logic        tag_vld_q, tag_vld_d, tag_id_q, tag_id_d;
   logic [3:0]  starve_q, starve_d;
   logic        req0, req1, gnt0, gnt1, acc, cmd_wr;
   // Grant selection: a lock pins the stalled master; in reset nobody is granted
   always_comb begin
      req0 = i_M0_Read | i_M0_Write;
      req1 = i_M1_Read | i_M1_Write;
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (i_Rst_n) begin
         case (state_q)
            LOCK_M0: gnt0 = req0;
            LOCK_M1: gnt1 = req1;
            default: begin
               gnt1 = req1 & (starve_q == LIMIT);
               gnt0 = req0 & ~gnt1;
               gnt1 = req1 & ~gnt0;
            end
         endcase
      end
      acc = (gnt0 | gnt1) & ~i_DBus_WaitRequest;
   end
   // Command mux to the shared bus; a write wins over a read from the same master
   always_comb begin
      cmd_wr           = gnt1 ? i_M1_Write : (gnt0 & i_M0_Write);
      o_DBus_Write     = cmd_wr;
      o_DBus_Read      = (gnt1 ? i_M1_Read : (gnt0 & i_M0_Read)) & ~cmd_wr;
      o_DBus_Address   = gnt1 ? i_M1_Address : gnt0 ? i_M0_Address : '0;
      o_DBus_ByteEn    = gnt1 ? i_M1_ByteEn : gnt0 ? i_M0_ByteEn : '0;
      o_DBus_WriteData = gnt1 ? i_M1_WriteData : gnt0 ? i_M0_WriteData : '0;
      o_M0_Wait        = req0 & ~(gnt0 & ~i_DBus_WaitRequest);
      o_M1_Wait        = req1 & ~(gnt1 & ~i_DBus_WaitRequest);
      o_M0_ReadValid   = tag_vld_q & ~tag_id_q;
      o_M1_ReadValid   = tag_vld_q & tag_id_q;
      o_M0_ReadData    = o_M0_ReadValid ? i_DBus_ReadData : '0;
      o_M1_ReadData    = o_M1_ReadValid ? i_DBus_ReadData : '0;
   end
   // Next state: any stalled grant locks to its master, everything else (incl. a dropped request) goes idle
   always_comb begin
      state_d   = ((gnt0 | gnt1) & i_DBus_WaitRequest) ? (gnt1 ? LOCK_M1 : LOCK_M0) : IDLE;
      tag_vld_d = acc & o_DBus_Read;
      tag_id_d  = gnt1;
      starve_d  = (~req1 | (acc & gnt1)) ? 4'd0 : (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
   end
   // State registers, cleared asynchronously so a reset drops any lock and in-flight read tag
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q   <= IDLE;
         tag_vld_q <= 1'b0;
         tag_id_q  <= 1'b0;
         starve_q  <= 4'd0;
      end else begin
         state_q   <= state_d;
         tag_vld_q <= tag_vld_d;
         tag_id_q  <= tag_id_d;
         starve_q  <= starve_d;
      end
   end
endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: vector table, hand-written corner sequences and randomized run against a reference model.
module tb_dbus_arbiter;
   localparam int LIM = 8;
   logic        clk, rst_n, stall;
   logic        rd[2], wr[2];
   logic [29:0] ad[2];
   logic [3:0]  be[2];
   logic [31:0] wd[2];
   logic [31:0] rdata;
   logic        o_M0_Wait, o_M0_ReadValid, o_M1_Wait, o_M1_ReadValid;
   logic [31:0] o_M0_ReadData, o_M1_ReadData;
   logic [29:0] o_DBus_Address;
   logic [3:0]  o_DBus_ByteEn;
   logic        o_DBus_Read, o_DBus_Write;
   logic [31:0] o_DBus_WriteData;
   int          checks = 0, errors = 0;
   int          m_lock, m_tag, m_starve;

   dbus_arbiter #(.p_STARVE_LIMIT(LIM)) dut (
      .i_Clk(clk), .i_Rst_n(rst_n),
      .i_M0_Address(ad[0]), .i_M0_ByteEn(be[0]), .i_M0_Read(rd[0]), .i_M0_Write(wr[0]),
      .i_M0_WriteData(wd[0]), .o_M0_Wait(o_M0_Wait), .o_M0_ReadData(o_M0_ReadData),
      .o_M0_ReadValid(o_M0_ReadValid),
      .i_M1_Address(ad[1]), .i_M1_ByteEn(be[1]), .i_M1_Read(rd[1]), .i_M1_Write(wr[1]),
      .i_M1_WriteData(wd[1]), .o_M1_Wait(o_M1_Wait), .o_M1_ReadData(o_M1_ReadData),
      .o_M1_ReadValid(o_M1_ReadValid),
      .o_DBus_Address(o_DBus_Address), .o_DBus_ByteEn(o_DBus_ByteEn), .o_DBus_Read(o_DBus_Read),
      .o_DBus_Write(o_DBus_Write), .o_DBus_WriteData(o_DBus_WriteData),
      .i_DBus_ReadData(rdata), .i_DBus_WaitRequest(stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  be0;
      logic        stall;
      logic [31:0] rdata;
      logic [1:0]  cmd;
      logic [29:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [1:0]  wt;
      logic [1:0]  rv;
      logic [31:0] r0;
      logic [31:0] r1;
   } vec_t;
   vec_t tv[16];

   task automatic chk(input string nm, input logic [95:0] a, input logic [95:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask

   function automatic int grant();
      bit r0, r1;
      r0 = rd[0] | wr[0];
      r1 = rd[1] | wr[1];
      if (!rst_n) return -1;
      if (m_lock >= 0) return (rd[m_lock] | wr[m_lock]) ? m_lock : -1;
      if (r1 && m_starve == LIM) return 1;
      if (r0) return 0;
      if (r1) return 1;
      return -1;
   endfunction

   task automatic model_reset();
      m_lock = -1;
      m_tag = -1;
      m_starve = 0;
   endtask

   task automatic model_check();
      int g;
      logic [67:0] ec;
      logic [1:0]  ew, ev;
      logic [31:0] er[2];
      g = grant();
      ec = '0;
      if (g >= 0) ec = {rd[g] & ~wr[g], wr[g], ad[g], be[g], wd[g]};
      for (int x = 0; x < 2; x++) begin
         ew[x] = (rd[x] | wr[x]) && !(g == x && !stall);
         ev[x] = (m_tag == x);
         er[x] = ev[x] ? rdata : 32'd0;
      end
      chk("model_cmd", {o_DBus_Read, o_DBus_Write, o_DBus_Address, o_DBus_ByteEn, o_DBus_WriteData}, ec);
      chk("model_wait", {o_M1_Wait, o_M0_Wait}, ew);
      chk("model_ret", {o_M1_ReadValid, o_M0_ReadValid, o_M1_ReadData, o_M0_ReadData}, {ev, er[1], er[0]});
   endtask

   task automatic model_update();
      int g;
      bit acc;
      if (!rst_n) begin
         model_reset();
         return;
      end
      g = grant();
      acc = (g >= 0) && !stall;
      m_tag = (acc && rd[g] && !wr[g]) ? g : -1;
      if (!(rd[1] | wr[1]) || (acc && g == 1)) m_starve = 0;
      else if (m_starve < LIM) m_starve++;
      m_lock = (g >= 0 && stall) ? g : -1;
   endtask

   task automatic settle();
      @(negedge clk);
      if (!rst_n) model_reset();
      model_check();
   endtask

   task automatic advance();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      for (int x = 0; x < 2; x++) begin
         rd[x] = 1'b0;
         wr[x] = 1'b0;
         be[x] = 4'hF;
         wd[x] = x ? 32'h22222222 : 32'h11111111;
         ad[x] = x ? 30'h200 : 30'h100;
      end
      stall = 1'b0;
      rdata = 32'd0;
   endtask

   initial begin
      tv[0]  = '{4'b0001, 4'hF, 1'b0, 32'h0,        2'b01, 30'h100, 4'hF, 32'h11111111, 2'b00, 2'b00, 32'h0,        32'h0};
      tv[1]  = '{4'b0000, 4'hF, 1'b0, 32'hDEADBEEF, 2'b00, 30'h0,   4'h0, 32'h0,        2'b00, 2'b01, 32'hDEADBEEF, 32'h0};
      tv[2]  = '{4'b1010, 4'hF, 1'b0, 32'h0,        2'b10, 30'h100, 4'hF, 32'h11111111, 2'b10, 2'b00, 32'h0,        32'h0};
      tv[3]  = '{4'b1000, 4'hF, 1'b0, 32'h0,        2'b10, 30'h200, 4'hF, 32'h22222222, 2'b00, 2'b00, 32'h0,        32'h0};
      tv[4]  = '{4'b0110, 4'h3, 1'b1, 32'h0,        2'b10, 30'h100, 4'h3, 32'h11111111, 2'b11, 2'b00, 32'h0,        32'h0};
      tv[5]  = tv[4];
      tv[6]  = tv[4];
      tv[7]  = '{4'b0110, 4'h3, 1'b0, 32'h0,        2'b10, 30'h100, 4'h3, 32'h11111111, 2'b10, 2'b00, 32'h0,        32'h0};
      tv[8]  = '{4'b0100, 4'hF, 1'b0, 32'h0,        2'b01, 30'h200, 4'hF, 32'h22222222, 2'b00, 2'b00, 32'h0,        32'h0};
      tv[9]  = '{4'b0000, 4'hF, 1'b0, 32'hCAFEF00D, 2'b00, 30'h0,   4'h0, 32'h0,        2'b00, 2'b10, 32'h0,        32'hCAFEF00D};
      tv[10] = '{4'b0001, 4'hF, 1'b0, 32'h0,        2'b01, 30'h100, 4'hF, 32'h11111111, 2'b00, 2'b00, 32'h0,        32'h0};
      tv[11] = '{4'b0100, 4'hF, 1'b0, 32'hAAAA0000, 2'b01, 30'h200, 4'hF, 32'h22222222, 2'b00, 2'b01, 32'hAAAA0000, 32'h0};
      tv[12] = '{4'b0000, 4'hF, 1'b0, 32'hBBBB1111, 2'b00, 30'h0,   4'h0, 32'h0,        2'b00, 2'b10, 32'h0,        32'hBBBB1111};
      tv[13] = '{4'b0000, 4'hF, 1'b0, 32'hCCCC2222, 2'b00, 30'h0,   4'h0, 32'h0,        2'b00, 2'b00, 32'h0,        32'h0};
      tv[14] = '{4'b0011, 4'hF, 1'b0, 32'h0,        2'b10, 30'h100, 4'hF, 32'h11111111, 2'b00, 2'b00, 32'h0,        32'h0};
      tv[15] = '{4'b0000, 4'hF, 1'b0, 32'h12345678, 2'b00, 30'h0,   4'h0, 32'h0,        2'b00, 2'b00, 32'h0,        32'h0};

      // reset with requests pending: no command, waits follow requests
      model_reset();
      idle_inputs();
      rst_n = 1'b0;
      rd[0] = 1'b1;
      wr[1] = 1'b1;
      settle();
      chk("rst_wait", {o_M1_Wait, o_M0_Wait}, 2'b11);
      chk("rst_cmd", {o_DBus_Read, o_DBus_Write}, 2'b00);
      chk("rst_ret", {o_M1_ReadValid, o_M0_ReadValid, o_M1_ReadData, o_M0_ReadData}, 66'd0);
      advance();
      settle();
      advance();
      rst_n = 1'b1;

      // directed vector table
      for (int i = 0; i < 16; i++) begin
         idle_inputs();
         {wr[1], rd[1], wr[0], rd[0]} = tv[i].req;
         be[0] = tv[i].be0;
         stall = tv[i].stall;
         rdata = tv[i].rdata;
         settle();
         chk($sformatf("tv%0d_cmd", i), {o_DBus_Write, o_DBus_Read, o_DBus_Address, o_DBus_ByteEn, o_DBus_WriteData},
             {tv[i].cmd, tv[i].addr, tv[i].be, tv[i].wd});
         chk($sformatf("tv%0d_wait", i), {o_M1_Wait, o_M0_Wait}, tv[i].wt);
         chk($sformatf("tv%0d_ret", i), {o_M1_ReadValid, o_M0_ReadValid, o_M0_ReadData, o_M1_ReadData},
             {tv[i].rv, tv[i].r0, tv[i].r1});
         advance();
      end

      // starvation: M1 wins after exactly LIM blocked cycles
      idle_inputs();
      rst_n = 1'b0;
      settle();
      advance();
      rst_n = 1'b1;
      for (int i = 0; i <= LIM; i++) begin
         wr[0] = 1'b1;
         wr[1] = 1'b1;
         settle();
         chk($sformatf("starve%0d_w1", i), o_M1_Wait, (i < LIM));
         chk($sformatf("starve%0d_addr", i), o_DBus_Address, (i < LIM) ? 30'h100 : 30'h200);
         if (i == LIM) chk("starve_full", dut.starve_q, LIM);
         advance();
      end
      chk("starve_cleared", dut.starve_q, 0);

      // reset with a read in flight, then reset during LOCK_M1
      idle_inputs();
      rd[0] = 1'b1;
      settle();
      advance();
      rd[0] = 1'b0;
      rd[1] = 1'b1;
      stall = 1'b1;
      rdata = 32'h5555AAAA;
      settle();
      chk("inflight_rv0", o_M0_ReadValid, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_inflight_ret", {o_M1_ReadValid, o_M0_ReadValid, o_M1_ReadData, o_M0_ReadData}, 66'd0);
      chk("rst_inflight_cmd", {o_DBus_Read, o_DBus_Write, o_M1_Wait}, 3'b001);
      advance();
      rst_n = 1'b1;
      settle();
      chk("no_deliver", {o_M1_ReadValid, o_M0_ReadValid}, 2'b00);
      chk("m1_stalled_grant", o_DBus_Address, 30'h200);
      advance();
      rd[0] = 1'b1;
      settle();
      chk("lock_m1_holds", {o_DBus_Address, o_M0_Wait}, {30'h200, 1'b1});
      #1 rst_n = 1'b0;
      #1;
      chk("rst_lock_cmd", {o_DBus_Read, o_DBus_Write, o_M1_Wait, o_M0_Wait}, 4'b0011);
      chk("rst_lock_rv", {o_M1_ReadValid, o_M0_ReadValid}, 2'b00);
      advance();
      rst_n = 1'b1;
      stall = 1'b0;
      settle();
      chk("post_rst_idle", o_DBus_Address, 30'h100);
      advance();

      // randomized run against the reference model
      for (int n = 0; n < 1500; n++) begin
         rst_n = ($urandom_range(0, 149) != 0);
         for (int x = 0; x < 2; x++) begin
            if ($urandom_range(0, 1) == 0) begin
               rd[x] = ($urandom_range(0, 9) < (x ? 5 : 7)) ? 1'($urandom_range(0, 1)) : 1'b0;
               wr[x] = ($urandom_range(0, 9) < (x ? 5 : 7)) ? 1'($urandom_range(0, 1)) : 1'b0;
               ad[x] = 30'($urandom);
               be[x] = 4'($urandom);
               wd[x] = $urandom;
            end
         end
         stall = ($urandom_range(0, 3) == 0);
         rdata = $urandom;
         settle();
         advance();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
